// File: rtl/wback_pkg.sv
// ============================================================================
// Module : wback_pkg
// Brief  : Shared rvga types and constants for the writeback stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wback_pkg;

  localparam int RVGA_WORD_W      = 32;
  localparam int RVGA_MEM_TIMEOUT = 255;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]             rd;
    logic [RVGA_WORD_W-1:0] rd_data;
    logic                   regfile_load;
    logic                   mem_read;
    logic [2:0]             ld_funct3;
    logic [RVGA_WORD_W-1:0] alu_result;
  } rvga_cword;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wback_load_align.sv
// ============================================================================
// Module : wback_load_align
// Brief  : Combinational load formatter (byte/halfword select, sign/zero ext).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wback_load_align
  import wback_pkg::*;
#(
  parameter int WORD_W = RVGA_WORD_W
) (
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic [1:0]        alu_result,
  input  logic [2:0]        ld_funct3,
  output logic [WORD_W-1:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = dmem_rdata[{alu_result, 3'b000} +: 8];
    // Misaligned halfwords ignore alu_result[0].
    w_half = dmem_rdata[{alu_result[1], 4'b0000} +: 16];
    case (ld_funct3)
      LD_LB:   ld_data = {{(WORD_W-8){w_byte[7]}}, w_byte};
      LD_LBU:  ld_data = {{(WORD_W-8){1'b0}}, w_byte};
      LD_LH:   ld_data = {{(WORD_W-16){w_half[15]}}, w_half};
      LD_LHU:  ld_data = {{(WORD_W-16){1'b0}}, w_half};
      LD_LW:   ld_data = dmem_rdata;
      default: ld_data = dmem_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wback.sv
// ============================================================================
// Module : wback
// Brief  : rvga writeback stage; waits on load data, formats it and issues
//          one registered regfile write per instruction. Optional bypass
//          history outputs are built when WB_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wback
  import wback_pkg::*;
#(
  parameter int WORD_W      = RVGA_WORD_W,
  parameter int MEM_TIMEOUT = RVGA_MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              mem_wb_valid,
  input  rvga_cword         mem_wb_cword,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  output rvga_cword         wb_rf_cword,
  output logic              wb_stall,
  output logic              wb_timeout
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [4:0]        byp_rd,
  output logic [WORD_W-1:0] byp_data
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t          r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  rvga_cword          r_pend, w_pend_n;
  rvga_cword          r_cword, w_cword_n;
  logic               r_timeout, w_timeout_n;
  rvga_cword          w_src;
  rvga_cword          w_loaded;
  logic [WORD_W-1:0]  w_fmt;
  logic               w_upd;

  // One formatter serves both the zero-wait and the delayed load path.
  assign w_src = (r_state == WB_WAIT_MEM) ? r_pend : mem_wb_cword;

  wback_load_align #(.WORD_W(WORD_W)) u_align (
    .dmem_rdata (dmem_rdata),
    .alu_result (w_src.alu_result[1:0]),
    .ld_funct3  (w_src.ld_funct3),
    .ld_data    (w_fmt)
  );

  always_comb begin
    w_loaded         = w_src;
    w_loaded.rd_data = w_fmt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WB_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_cword   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_pend    <= w_pend_n;
      r_cword   <= w_cword_n;
      r_timeout <= w_timeout_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_pend_n    = r_pend;
    w_cword_n   = r_cword;
    w_timeout_n = r_timeout;
    w_upd       = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (!stall) begin
          w_upd = 1'b1;
          if (!mem_wb_valid) begin
            w_cword_n.regfile_load = 1'b0;
          end else if (!mem_wb_cword.mem_read) begin
            w_cword_n = mem_wb_cword;
          end else if (dmem_rvalid) begin
            w_cword_n = w_loaded;
          end else begin
            w_pend_n               = mem_wb_cword;
            w_cword_n.regfile_load = 1'b0;
            w_cnt_n                = '0;
            w_state_n              = WB_WAIT_MEM;
          end
        end
      end
      WB_WAIT_MEM: begin
        // Global stall is ignored here so returning data is never dropped.
        w_upd = 1'b1;
        if (dmem_rvalid) begin
          w_cword_n = w_loaded;
          w_cnt_n   = '0;
          w_state_n = WB_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_cword_n.regfile_load = 1'b0;
          w_timeout_n            = 1'b1;
          w_cnt_n                = '0;
          w_state_n              = WB_IDLE;
        end else begin
          w_cword_n.regfile_load = 1'b0;
          w_cnt_n                = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = WB_IDLE;
    endcase
  end

  assign wb_rf_cword = r_cword;
  assign wb_stall    = (r_state == WB_WAIT_MEM);
  assign wb_timeout  = r_timeout;

`ifdef WB_BYPASS_EN
  logic              r_byp_valid;
  logic [4:0]        r_byp_rd;
  logic [WORD_W-1:0] r_byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_valid <= 1'b0;
      r_byp_rd    <= '0;
      r_byp_data  <= '0;
    end else if (w_upd) begin
      r_byp_valid <= w_cword_n.regfile_load && (w_cword_n.rd != 5'd0);
      if (w_cword_n.regfile_load && (w_cword_n.rd != 5'd0)) begin
        r_byp_rd   <= w_cword_n.rd;
        r_byp_data <= w_cword_n.rd_data;
      end
    end
  end

  assign byp_valid = r_byp_valid;
  assign byp_rd    = r_byp_rd;
  assign byp_data  = r_byp_data;
`else
  logic w_upd_unused;
  assign w_upd_unused = w_upd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wback.sv
// ============================================================================
// Module : tb_wback
// Brief  : Self-checking bench for wback with a behavioural load model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wback;
  import wback_pkg::*;

  localparam int TMO = 4;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      stall = 1'b0;
  logic      mem_wb_valid = 1'b0;
  rvga_cword mem_wb_cword = '0;
  logic [31:0] dmem_rdata = '0;
  logic      dmem_rvalid = 1'b0;
  rvga_cword wb_rf_cword;
  logic      wb_stall;
  logic      wb_timeout;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  rvga_cword exp_cw = '0;

  wback #(.WORD_W(32), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_cword (mem_wb_cword),
    .dmem_rdata   (dmem_rdata),
    .dmem_rvalid  (dmem_rvalid),
    .wb_rf_cword  (wb_rf_cword),
    .wb_stall     (wb_stall),
    .wb_timeout   (wb_timeout)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid    (byp_valid),
    .byp_rd       (byp_rd),
    .byp_data     (byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load result from the ISA rules: pick byte/halfword by address, extend.
  function automatic logic [31:0] ref_fmt(logic [31:0] d, logic [1:0] a, logic [2:0] f);
    int unsigned bsh = 8 * int'(a);
    int unsigned hsh = 16 * int'(a[1]);
    logic [31:0] bv = (d >> bsh) & 32'hFF;
    logic [31:0] hv = (d >> hsh) & 32'hFFFF;
    case (f)
      3'b000:  return (bv >= 32'h80) ? (bv - 32'h100) : bv;
      3'b100:  return bv;
      3'b001:  return (hv >= 32'h8000) ? (hv - 32'h10000) : hv;
      3'b101:  return hv;
      default: return d;
    endcase
  endfunction

  function automatic rvga_cword rand_cw(logic is_load);
    rvga_cword c;
    c.rd           = 5'($urandom);
    c.rd_data      = $urandom;
    c.regfile_load = 1'($urandom);
    c.mem_read     = is_load;
    c.ld_funct3    = 3'($urandom);
    c.alu_result   = $urandom;
    return c;
  endfunction

  function automatic rvga_cword as_loaded(rvga_cword c, logic [31:0] d);
    rvga_cword r = c;
    r.rd_data = ref_fmt(d, c.alu_result[1:0], c.ld_funct3);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_cw = '0;
    n_checks++;
    if (wb_rf_cword !== exp_cw) begin
      n_fail++; $display("FAIL reset_cword got=%h exp=%h", wb_rf_cword, exp_cw);
    end
    n_checks++;
    if (wb_stall !== 1'b0 || wb_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got stall=%b tmo=%b exp 0 0", wb_stall, wb_timeout);
    end
  endtask

  task automatic test_alu_pass();
    for (int i = 0; i < 9; i++) begin
      rvga_cword c = rand_cw(1'b0);
      if (i == 0) begin
        c.rd = 5'd5; c.rd_data = 32'hDEADBEEF; c.regfile_load = 1'b1;
      end
      mem_wb_valid = 1'b1; mem_wb_cword = c; dmem_rvalid = 1'($urandom);
      tick();
      exp_cw = c;
      n_checks++;
      if (wb_rf_cword !== exp_cw || wb_stall !== 1'b0) begin
        n_fail++; $display("FAIL alu_pass[%0d] got=%h stall=%b exp=%h stall=0", i, wb_rf_cword, wb_stall, exp_cw);
      end
    end
    mem_wb_valid = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 20; i++) begin
      rvga_cword c = rand_cw(1'b1);
      logic [31:0] d = $urandom;
      if (i == 0) begin
        c.alu_result = 32'h1003; c.ld_funct3 = LD_LB; c.regfile_load = 1'b1; d = 32'h80123456;
      end
      mem_wb_valid = 1'b1; mem_wb_cword = c; dmem_rdata = d; dmem_rvalid = 1'b1;
      tick();
      exp_cw = as_loaded(c, d);
      if (i == 0) begin
        n_checks++;
        if (wb_rf_cword.rd_data !== 32'hFFFFFF80) begin
          n_fail++; $display("FAIL zw_lb_example got=%h exp=ffffff80", wb_rf_cword.rd_data);
        end
      end
      n_checks++;
      if (wb_rf_cword !== exp_cw || wb_stall !== 1'b0) begin
        n_fail++; $display("FAIL zero_wait[%0d] got=%h stall=%b exp=%h", i, wb_rf_cword, wb_stall, exp_cw);
      end
    end
    mem_wb_valid = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic test_delayed();
    for (int i = 0; i < 8; i++) begin
      rvga_cword c = rand_cw(1'b1);
      logic [31:0] d = $urandom;
      int dly = (i == 7) ? TMO : int'($urandom_range(1, TMO));
      if (i == 0) begin
        c.alu_result = 32'h2002; c.ld_funct3 = LD_LHU; c.regfile_load = 1'b1;
        d = 32'hABCD1234; dly = 3;
      end
      mem_wb_valid = 1'b1; mem_wb_cword = c; dmem_rvalid = 1'b0;
      tick();
      mem_wb_valid = 1'b0; mem_wb_cword = rand_cw(1'b0);
      for (int k = 1; k <= dly; k++) begin
        n_checks++;
        if (wb_stall !== 1'b1 || wb_rf_cword.regfile_load !== 1'b0) begin
          n_fail++; $display("FAIL delayed_wait[%0d] cyc=%0d got stall=%b rl=%b exp 1 0", i, k, wb_stall, wb_rf_cword.regfile_load);
        end
        stall = 1'($urandom);
        dmem_rdata = $urandom;
        if (k == dly) begin
          dmem_rdata = d; dmem_rvalid = 1'b1;
        end
        tick();
        dmem_rvalid = 1'b0;
      end
      stall = 1'b0;
      exp_cw = as_loaded(c, d);
      if (i == 0) begin
        n_checks++;
        if (wb_rf_cword.rd_data !== 32'h0000ABCD || wb_rf_cword.regfile_load !== 1'b1) begin
          n_fail++; $display("FAIL delayed_lhu_example got=%h rl=%b exp=0000abcd 1", wb_rf_cword.rd_data, wb_rf_cword.regfile_load);
        end
      end
      n_checks++;
      if (wb_rf_cword !== exp_cw || wb_stall !== 1'b0 || wb_timeout !== 1'b0) begin
        n_fail++; $display("FAIL delayed_done[%0d] dly=%0d got=%h stall=%b tmo=%b exp=%h 0 0", i, dly, wb_rf_cword, wb_stall, wb_timeout, exp_cw);
      end
    end
  endtask

  task automatic test_timeout();
    rvga_cword c = rand_cw(1'b1);
    rvga_cword a = rand_cw(1'b0);
    c.regfile_load = 1'b1;
    mem_wb_valid = 1'b1; mem_wb_cword = c; dmem_rvalid = 1'b0;
    tick();
    mem_wb_valid = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      n_checks++;
      if (wb_stall !== 1'b1 || wb_rf_cword.regfile_load !== 1'b0 || wb_timeout !== 1'b0) begin
        n_fail++; $display("FAIL timeout_wait cyc=%0d got stall=%b rl=%b tmo=%b exp 1 0 0", k, wb_stall, wb_rf_cword.regfile_load, wb_timeout);
      end
      tick();
    end
    n_checks++;
    if (wb_stall !== 1'b0 || wb_timeout !== 1'b1 || wb_rf_cword.regfile_load !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flag got stall=%b tmo=%b rl=%b exp 0 1 0", wb_stall, wb_timeout, wb_rf_cword.regfile_load);
    end
    mem_wb_valid = 1'b1; mem_wb_cword = a;
    tick();
    mem_wb_valid = 1'b0;
    exp_cw = a;
    n_checks++;
    if (wb_timeout !== 1'b1 || wb_rf_cword !== exp_cw) begin
      n_fail++; $display("FAIL timeout_sticky got tmo=%b cw=%h exp 1 %h", wb_timeout, wb_rf_cword, exp_cw);
    end
  endtask

  task automatic test_stall_hold();
    rvga_cword h = rand_cw(1'b0);
    rvga_cword n = rand_cw(1'b0);
    h.rd_data = 32'h11; h.regfile_load = 1'b1;
    mem_wb_valid = 1'b1; mem_wb_cword = h;
    tick();
    stall = 1'b1; mem_wb_cword = n;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (wb_rf_cword !== h) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", k, wb_rf_cword, h);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (wb_rf_cword !== n) begin
      n_fail++; $display("FAIL stall_release got=%h exp=%h", wb_rf_cword, n);
    end
    // Stray rvalid with no load presented must only produce a bubble.
    mem_wb_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    tick();
    dmem_rvalid = 1'b0;
    exp_cw = n; exp_cw.regfile_load = 1'b0;
    n_checks++;
    if (wb_rf_cword !== exp_cw || wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL idle_rvalid got=%h stall=%b exp=%h 0", wb_rf_cword, wb_stall, exp_cw);
    end
  endtask

  task automatic test_async_reset();
    rvga_cword c = rand_cw(1'b1);
    rvga_cword a = rand_cw(1'b0);
    mem_wb_valid = 1'b1; mem_wb_cword = c; dmem_rvalid = 1'b0;
    tick();
    mem_wb_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wb_rf_cword !== '0 || wb_stall !== 1'b0 || wb_timeout !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got cw=%h stall=%b tmo=%b exp 0 0 0", wb_rf_cword, wb_stall, wb_timeout);
    end
    #1 rst_n = 1'b1;
    mem_wb_valid = 1'b1; mem_wb_cword = a; dmem_rvalid = 1'b1;
    tick();
    mem_wb_valid = 1'b0; dmem_rvalid = 1'b0;
    n_checks++;
    if (wb_rf_cword !== a || wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL after_async_reset got=%h stall=%b exp=%h 0", wb_rf_cword, wb_stall, a);
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    rvga_cword c = '0;
    c.rd = 5'd7; c.rd_data = 32'h55; c.regfile_load = 1'b1;
    mem_wb_valid = 1'b1; mem_wb_cword = c;
    tick();
    mem_wb_valid = 1'b0;
    n_checks++;
    if (byp_valid !== 1'b1 || byp_rd !== 5'd7 || byp_data !== 32'h55) begin
      n_fail++; $display("FAIL bypass_hit got v=%b rd=%0d d=%h exp 1 7 55", byp_valid, byp_rd, byp_data);
    end
    tick();
    n_checks++;
    if (byp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_clear got v=%b exp 0", byp_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_pass();
    test_zero_wait();
    test_delayed();
    test_timeout();
    test_stall_hold();
    test_async_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
